// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction-fetch stage. It owns the program counter, issues in-order
// requests to instruction memory and keeps up to two returned instructions in
// a small prefetch buffer that feeds the IF/ID register directly. A branch
// redirect flushes the buffer and drops the responses of every request that
// was already in flight.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   reset_i        synchronous, active-low reset
//   imem_req_o     fetch request valid
//   imem_addr_o    fetch address (word aligned)
//   imem_gnt_i     request accepted this cycle (only meaningful with req)
//   imem_rvalid_i  response valid, responses return in request order
//   imem_rdata_i   response instruction
//   redirect_i     branch/jump taken: flush and refetch
//   redirect_pc_i  new fetch address, bits [1:0] ignored
//   stall_i        IF/ID register cannot accept this cycle
//   instr_valid_o  buffer head valid
//   instr_o        buffer head instruction (0 when empty)
//   instr_pc_o     PC of buffer head (0 when empty)
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [DATA_W-1:0] imem_rdata_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              stall_i,
   output logic              instr_valid_o,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] instr_pc_o
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   // Control state
   logic [ADDR_W-1:0] r_fetch_pc;     // address of the next request
   logic [ADDR_W-1:0] r_resp_pc;      // PC belonging to the next kept response
   logic [1:0]        r_outstanding;  // granted, response not yet seen
   logic [1:0]        r_discard;      // stale responses still to be dropped
   logic [1:0]        r_count;        // prefetch buffer occupancy

   // Prefetch buffer, slot 0 is the head
   entry_t            r_fifo [2];

   logic              w_pop;
   logic              w_rsp;
   logic              w_push;
   logic              w_req;
   logic              w_grant;
   logic [2:0]        w_inflight;
   logic [1:0]        w_out_after_rsp;
   logic [ADDR_W-1:0] w_redirect_pc;
   entry_t            w_new_entry;

   assign w_pop = instr_valid_o & ~stall_i;

   // A response with nothing outstanding belongs to a request abandoned by a
   // reset, so it is ignored entirely.
   assign w_rsp = imem_rvalid_i & (r_outstanding != 2'd0);

   // Kept responses only: stale ones are counted off by r_discard, and the
   // buffer is being flushed in a redirect cycle anyway.
   assign w_push = reset_i & ~redirect_i & w_rsp & (r_discard == 2'd0);

   // Credit rule: every granted request must have a buffer slot waiting for
   // it, counting the slot freed by this cycle's pop. This is what keeps the
   // two-entry buffer from ever overflowing.
   assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count} - {2'b00, w_pop};
   assign w_req      = reset_i & ~redirect_i & (w_inflight < 3'd2);
   assign w_grant    = w_req & imem_gnt_i;

   assign w_out_after_rsp = r_outstanding - {1'b0, w_rsp};
   assign w_redirect_pc   = redirect_pc_i & ~ADDR_W'(3);
   assign w_new_entry     = '{pc: r_resp_pc, instr: imem_rdata_i};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= 2'd0;
         r_discard     <= 2'd0;
         r_count       <= 2'd0;
      end else if (redirect_i) begin
         // Everything still in flight after this cycle's response is stale;
         // this overwrites any discard already in progress.
         r_fetch_pc    <= w_redirect_pc;
         r_resp_pc     <= w_redirect_pc;
         r_outstanding <= w_out_after_rsp;
         r_discard     <= w_out_after_rsp;
         r_count       <= 2'd0;
      end else begin
         if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
         end
         r_outstanding <= w_out_after_rsp + {1'b0, w_grant};
         if (w_rsp && (r_discard != 2'd0)) begin
            r_discard <= r_discard - 2'd1;
         end
         if (w_push) begin
            r_resp_pc <= r_resp_pc + PC_STEP;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // NOTE: the buffer payload has no reset; r_count alone decides whether a
   // slot is meaningful, and the outputs are forced to 0 when it is empty.
   always_ff @(posedge clk_i) begin
      if (w_pop) begin
         r_fifo[0] <= r_fifo[1];
      end
      // Write slot is the occupancy after the pop; a push with a pop at
      // count=1 lands in the head and overrides the shift above.
      if (w_push) begin
         if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) begin
            r_fifo[0] <= w_new_entry;
         end else begin
            r_fifo[1] <= w_new_entry;
         end
      end
   end

   assign imem_req_o    = w_req;
   assign imem_addr_o   = r_fetch_pc;
   assign instr_valid_o = reset_i & (r_count != 2'd0);
   assign instr_o       = instr_valid_o ? r_fifo[0].instr : '0;
   assign instr_pc_o    = instr_valid_o ? r_fifo[0].pc    : '0;

endmodule
